// File: rtl/walk_register_pkg.sv
// Shared constants and types for the pedestrian walk-request latch.
// Used by walk_request_register and walk_request_cell.
package walk_register_pkg;

  localparam int NUM_WALK_DEF = 1;
  localparam int CNT_W_DEF    = 8;

  // Largest value the default-width request counter can hold before it saturates.
  localparam int CNT_SAT_DEF  = (1 << CNT_W_DEF) - 1;

  typedef enum logic {
    LEVEL = 1'b0,
    EDGE  = 1'b1
  } set_mode_e;

endpackage

// File: rtl/walk_request_cell.sv
// Single-lane sticky walk-request latch with optional rising-edge qualification.
// Optional macro WALK_REG_COUNT_EN adds a saturating accepted-request counter.
module walk_request_cell
  import walk_register_pkg::*;
#(
  parameter set_mode_e SET_MODE = LEVEL
`ifdef WALK_REG_COUNT_EN
  ,
  parameter int        CNT_W    = CNT_W_DEF
`endif
) (
  input  logic clock,
  input  logic reset_sync,
  input  logic wr_sync,
  input  logic wr_reset,
  output logic wr
`ifdef WALK_REG_COUNT_EN
  ,
  output logic [CNT_W-1:0] req_count
`endif
);

  logic wr_q, wr_d;
  logic prev_q, prev_d;
  logic set_cond;

  always_comb begin
    set_cond = (SET_MODE == EDGE) ? (wr_sync & ~prev_q) : wr_sync;
    prev_d   = wr_sync;
    // Clear beats set so the controller can always retire a served request.
    if (wr_reset) begin
      wr_d = 1'b0;
    end else if (set_cond) begin
      wr_d = 1'b1;
    end else begin
      wr_d = wr_q;
    end
  end

  always_ff @(posedge clock or negedge reset_sync) begin
    if (!reset_sync) begin
      wr_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      prev_q <= prev_d;
    end
  end

  assign wr = wr_q;

`ifdef WALK_REG_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Only a request that actually flips the latch from idle counts as accepted.
  always_comb begin
    cnt_d = cnt_q;
    if (!wr_q && set_cond && !wr_reset && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_sync) begin
    if (!reset_sync) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign req_count = cnt_q;
`endif

endmodule

// File: rtl/walk_request_register.sv
// Multi-lane sticky walk-request register between the button synchronizer and controller FSM.
// Optional macro WALK_REG_COUNT_EN adds the per-lane req_count output.
module walk_request_register
  import walk_register_pkg::*;
#(
  parameter int NUM_WALK    = NUM_WALK_DEF,
  parameter int SET_ON_EDGE = 0,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                clock,
  input  logic                reset_sync,
  input  logic [NUM_WALK-1:0] wr_sync,
  input  logic [NUM_WALK-1:0] wr_reset,
  output logic [NUM_WALK-1:0] wr
`ifdef WALK_REG_COUNT_EN
  ,
  output logic [NUM_WALK*CNT_W-1:0] req_count
`endif
);

  localparam set_mode_e SET_MODE = (SET_ON_EDGE != 0) ? EDGE : LEVEL;

  if ((NUM_WALK < 1) || (NUM_WALK > 16) || (CNT_W < 1)) begin : g_param_err
    $error("walk_request_register: NUM_WALK must be 1..16 and CNT_W at least 1");
  end

  for (genvar gi = 0; gi < NUM_WALK; gi++) begin : g_lane
    walk_request_cell #(
      .SET_MODE (SET_MODE)
`ifdef WALK_REG_COUNT_EN
      ,
      .CNT_W    (CNT_W)
`endif
    ) u_cell (
      .clock      (clock),
      .reset_sync (reset_sync),
      .wr_sync    (wr_sync[gi]),
      .wr_reset   (wr_reset[gi]),
      .wr         (wr[gi])
`ifdef WALK_REG_COUNT_EN
      ,
      .req_count  (req_count[gi*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_walk_request_register.sv
// Randomized plus directed bench for walk_request_register in level and edge modes.
// Counter checks are active when WALK_REG_COUNT_EN is defined.
module tb_walk_request_register;

  localparam int NW = 2;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_sync;
  logic [NW-1:0] wr_sync, wr_reset;
  logic [NW-1:0] wr_lvl, wr_edg;
`ifdef WALK_REG_COUNT_EN
  logic [NW*CW-1:0] cnt_lvl, cnt_edg;
`endif

  always #5 clock = ~clock;

  walk_request_register #(.NUM_WALK(NW), .SET_ON_EDGE(0), .CNT_W(CW)) dut_lvl (
    .clock      (clock),
    .reset_sync (reset_sync),
    .wr_sync    (wr_sync),
    .wr_reset   (wr_reset),
    .wr         (wr_lvl)
`ifdef WALK_REG_COUNT_EN
    ,
    .req_count  (cnt_lvl)
`endif
  );

  walk_request_register #(.NUM_WALK(NW), .SET_ON_EDGE(1), .CNT_W(CW)) dut_edg (
    .clock      (clock),
    .reset_sync (reset_sync),
    .wr_sync    (wr_sync),
    .wr_reset   (wr_reset),
    .wr         (wr_edg)
`ifdef WALK_REG_COUNT_EN
    ,
    .req_count  (cnt_edg)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: index [mode][lane], mode 0 = level, 1 = edge.
  bit m_wr   [2][NW];
  bit m_prev [2][NW];
  int m_cnt  [2][NW];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++)
      for (int l = 0; l < NW; l++) begin
        m_wr[m][l]   = 1'b0;
        m_prev[m][l] = 1'b0;
        m_cnt[m][l]  = 0;
      end
  endfunction

  function automatic void model_step(input logic [NW-1:0] s, input logic [NW-1:0] c);
    bit req;
    for (int m = 0; m < 2; m++)
      for (int l = 0; l < NW; l++) begin
        req = s[l] && ((m == 0) || !m_prev[m][l]);
        if (c[l]) begin
          m_wr[m][l] = 1'b0;
        end else if (req) begin
          if (!m_wr[m][l] && m_cnt[m][l] < CNT_MAX) m_cnt[m][l]++;
          m_wr[m][l] = 1'b1;
        end
        m_prev[m][l] = s[l];
      end
  endfunction

  task automatic compare(input string tag);
    logic [NW-1:0] e_lvl, e_edg;
    for (int l = 0; l < NW; l++) begin
      e_lvl[l] = m_wr[0][l];
      e_edg[l] = m_wr[1][l];
    end
    check({tag, "_wr_lvl"}, 32'(wr_lvl), 32'(e_lvl));
    check({tag, "_wr_edg"}, 32'(wr_edg), 32'(e_edg));
`ifdef WALK_REG_COUNT_EN
    for (int l = 0; l < NW; l++) begin
      check({tag, "_cnt_lvl"}, 32'(cnt_lvl[l*CW +: CW]), 32'(m_cnt[0][l]));
      check({tag, "_cnt_edg"}, 32'(cnt_edg[l*CW +: CW]), 32'(m_cnt[1][l]));
    end
`endif
  endtask

  // Called away from the rising edge; drives inputs, advances one edge, checks #1 later.
  task automatic step(input string tag, input logic [NW-1:0] s, input logic [NW-1:0] c);
    wr_sync  = s;
    wr_reset = c;
    @(posedge clock);
    if (reset_sync) model_step(s, c);
    #1;
    compare(tag);
  endtask

  initial begin
    reset_sync = 1'b0;
    wr_sync    = '0;
    wr_reset   = '0;
    model_reset();

    // Requests presented during reset must be ignored.
    for (int i = 0; i < 5; i++) begin
      step("rst_hold", 2'b11, 2'b00);
      check("rst_hold_const", 32'(wr_lvl | wr_edg), 32'h0);
    end

    reset_sync = 1'b1;
    step("release", 2'b00, 2'b00);

    step("set_pulse", 2'b01, 2'b00);
    check("set_lat_lvl", 32'(wr_lvl), 32'h1);
    check("set_lat_edg", 32'(wr_edg), 32'h1);
    for (int i = 0; i < 22; i++) step("hold", 2'b00, 2'b00);
    check("hold_const", 32'(wr_lvl), 32'h1);

    step("multilane", 2'b00, 2'b10);
    check("multilane_const", 32'(wr_lvl), 32'h1);

    step("clear", 2'b00, 2'b01);
    check("clear_const", 32'(wr_lvl | wr_edg), 32'h0);

    step("simul", 2'b01, 2'b01);
    step("simul", 2'b01, 2'b01);
    check("simul_const", 32'(wr_lvl | wr_edg), 32'h0);
    step("simul_drop", 2'b01, 2'b00);
    check("simul_drop_lvl", 32'(wr_lvl), 32'h1);
    check("simul_drop_edg", 32'(wr_edg), 32'h0);
    step("idle", 2'b00, 2'b11);

    // Repeated set on lane 1 while latched must not count twice.
    step("reset_lane1", 2'b10, 2'b00);
    step("reset_lane1", 2'b10, 2'b00);
    step("reset_lane1", 2'b00, 2'b00);
    step("reset_lane1", 2'b10, 2'b00);
`ifdef WALK_REG_COUNT_EN
    check("no_recount_lvl", 32'(cnt_lvl[CW +: CW]), 32'h1);
    check("no_recount_edg", 32'(cnt_edg[CW +: CW]), 32'h1);
`endif

    for (int i = 0; i < 5; i++) begin
      step("sat_set", 2'b01, 2'b00);
      step("sat_clr", 2'b00, 2'b01);
    end
`ifdef WALK_REG_COUNT_EN
    check("sat_lvl", 32'(cnt_lvl[0 +: CW]), 32'h3);
    check("sat_edg", 32'(cnt_edg[0 +: CW]), 32'h3);
`endif

    // Asynchronous reset mid-cycle, no clock edge in between.
    step("pre_async", 2'b11, 2'b00);
    #2;
    reset_sync = 1'b0;
    #1;
    model_reset();
    check("async_rst_lvl", 32'(wr_lvl), 32'h0);
    check("async_rst_edg", 32'(wr_edg), 32'h0);
    compare("async_rst");
    step("async_hold", 2'b11, 2'b00);
    reset_sync = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [NW-1:0] s, c;
      s = NW'($urandom);
      for (int l = 0; l < NW; l++) c[l] = ($urandom_range(0, 3) == 0);
      step("rand", s, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
